alu_operand_stage: RTL

//  Registered ALU operand-select stage between Decoder/Register File and ALU.

---
 rtl/alu_operand_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand-select stage between decode/register file and the ALU.
// Selects operand A (rs1/PC/zero) and operand B (rs2/sign-extended imm) and a store-data copy of rs2.
// Holds the result in a one-entry valid/ready pipeline register.
// Optional feature macro: ALU_OPERAND_FWD_EN enables EX/WB forwarding for rs1 and rs2.
// When the macro is undefined, register-file data is used directly and the ex_*/wb_* inputs are ignored.
module alu_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IMM_W  = 21,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    // decode bundle handshake
    input  logic              in_valid,
    output logic              in_ready,
    // operand selection controls
    input  logic              alu_src,
    input  logic [1:0]        a_sel,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   pc,
    input  logic [IMM_W-1:0]  imm,
    // forwarding sources
    input  logic              ex_wr_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_result,
    // pipeline control
    input  logic              flush,
    // ALU bundle handshake
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   store_data
);

    localparam int unsigned EXT_W = XLEN - IMM_W;

    localparam logic [1:0]        A_SEL_RS1 = 2'b00;
    localparam logic [1:0]        A_SEL_PC  = 2'b01;
    localparam logic [REG_AW-1:0] REG_X0    = '0;

    // forwarded source values
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // selected operands for the incoming bundle
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] op_a_new;
    logic [XLEN-1:0] op_b_new;

    // pipeline register
    logic            out_valid_q;
    logic            out_valid_d;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_a_d;
    logic [XLEN-1:0] op_b_q;
    logic [XLEN-1:0] op_b_d;
    logic [XLEN-1:0] store_data_q;
    logic [XLEN-1:0] store_data_d;

    logic            load;

`ifdef ALU_OPERAND_FWD_EN
    // Resolve RAW hazards: EX is younger than WB so it wins; x0 is never forwarded.
    always_comb begin
        rs1_fwd = rs1_data;
        rs2_fwd = rs2_data;
        if (rs1_addr != REG_X0) begin
            if (ex_wr_en && (ex_rd == rs1_addr)) begin
                rs1_fwd = ex_result;
            end else if (wb_wr_en && (wb_rd == rs1_addr)) begin
                rs1_fwd = wb_result;
            end
        end
        if (rs2_addr != REG_X0) begin
            if (ex_wr_en && (ex_rd == rs2_addr)) begin
                rs2_fwd = ex_result;
            end else if (wb_wr_en && (wb_rd == rs2_addr)) begin
                rs2_fwd = wb_result;
            end
        end
    end
`else
    // No forwarding: register-file values pass straight through.
    always_comb begin
        rs1_fwd = rs1_data;
        rs2_fwd = rs2_data;
    end

    // Forwarding inputs stay on the port list for a uniform interface but are not consumed.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs1_addr, rs2_addr, ex_wr_en, ex_rd, ex_result,
                                 wb_wr_en, wb_rd, wb_result};
`endif

    // Sign-extend the decoder immediate to the datapath width.
    assign imm_sext = {{EXT_W{imm[IMM_W-1]}}, imm};

    // Operand selection; unused/reserved encodings drive zero.
    always_comb begin
        op_a_new = '0;
        case (a_sel)
            A_SEL_RS1: op_a_new = rs1_fwd;
            A_SEL_PC:  op_a_new = pc;
            default:   op_a_new = '0;
        endcase
        op_b_new = alu_src ? imm_sext : rs2_fwd;
    end

    // Ready whenever the register is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Next-state: flush beats load, load beats drain; data holds unless a bundle is loaded.
    always_comb begin
        out_valid_d  = out_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        store_data_d = store_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d  = 1'b1;
            op_a_d       = op_a_new;
            op_b_d       = op_b_new;
            store_data_d = rs2_fwd;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            store_data_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            store_data_q <= store_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign store_data = store_data_q;

endmodule
